// File: rtl/biquad_coeff_pkg.sv
// Shared constants for the biquad coefficient register block: bank map, depths,
// CTRL bit positions and per-bank offsets into the flattened coefficient bus.
package biquad_coeff_pkg;

  localparam int unsigned NBANK           = 7;
  localparam int unsigned NCOEF_TOTAL     = 25;
  localparam logic [6:0]  CTRL_ADDR       = 7'h00;
  localparam int unsigned CTRL_UPDATE_BIT = 0;
  localparam int unsigned CTRL_ENABLE_BIT = 16;

  // Bank order: ZFIR, C, INCR, FCHAIN, GCHAIN, FCROSS, GCROSS.
  function automatic int unsigned bank_depth(input int unsigned b);
    case (b)
      0:       return 8;
      1:       return 4;
      2:       return 4;
      3:       return 3;
      4:       return 4;
      5:       return 1;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned bank_off(input int unsigned b);
    int unsigned off = 0;
    for (int unsigned i = 0; i < b; i++) off += bank_depth(i);
    return off;
  endfunction

  function automatic logic [6:0] bank_base(input int unsigned b);
    return 7'(4 * (b + 1));
  endfunction

endpackage

// File: rtl/biquad_coeff_bank.sv
// One coefficient bank: shift-in staging registers plus a saturating write count.
module biquad_coeff_bank #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned COEF_BITS = 18
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_i,
  input  logic                         clr_i,
  input  logic [COEF_BITS-1:0]         dat_i,
  output logic [DEPTH*COEF_BITS-1:0]   stage_o,
  output logic [7:0]                   count_o
);

  logic [COEF_BITS-1:0] r_stage [DEPTH];
  logic [7:0]           r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      r_count <= '0;
    end else begin
      if (wr_i) begin
        r_stage[0] <= dat_i;
        for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
      // A write coinciding with a commit counts as the first write of the new round.
      if (clr_i) begin
        r_count <= {7'b0, wr_i};
      end else if (wr_i && (r_count < 8'(DEPTH))) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_out
    assign stage_o[i*COEF_BITS +: COEF_BITS] = r_stage[i];
  end

  assign count_o = r_count;

endmodule

// File: rtl/biquad_coeff_wbs.sv
// Wishbone classic slave holding staged biquad coefficients; a commit copies all
// staging banks to the active coefficient bus in one cycle.
module biquad_coeff_wbs
  import biquad_coeff_pkg::*;
#(
  parameter int unsigned COEF_BITS = 18,
  parameter int unsigned NCOEF     = 25
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [6:0]                 wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  input  logic [3:0]                 wb_sel_i,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_rty_o,
  output logic [31:0]                wb_dat_o,
  input  logic                       global_update_i,
  output logic [NCOEF*COEF_BITS-1:0] coef_o,
  output logic                       update_o,
  output logic                       bypass_o
);

  logic [1:0]                 r_rst_sync;
  logic                       w_rst_n;
  logic                       r_ack;
  logic                       r_update;
  logic                       r_enable;
  logic                       r_bypass;
  logic [31:0]                r_dat;
  logic [NCOEF*COEF_BITS-1:0] r_coef;
  logic [NCOEF*COEF_BITS-1:0] w_stage;
  logic [7:0]                 w_count [NBANK];
  logic [COEF_BITS-1:0]       w_head  [NBANK];
  logic                       w_req;
  logic                       w_wr;
  logic                       w_ctrl_wr;
  logic                       w_update;
  logic [31:0]                w_rdata;
  logic                       w_unused;

  // Asynchronous assert, synchronous release.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_req & wb_we_i;
  assign w_ctrl_wr = w_wr & (wb_adr_i == CTRL_ADDR);
  assign w_update  = (w_ctrl_wr & wb_dat_i[CTRL_UPDATE_BIT]) | global_update_i;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    localparam int unsigned Depth = bank_depth(b);
    localparam int unsigned Off   = bank_off(b);
    logic [Depth*COEF_BITS-1:0] w_flat;

    biquad_coeff_bank #(
      .DEPTH     (Depth),
      .COEF_BITS (COEF_BITS)
    ) u_bank (
      .clk_i   (wb_clk_i),
      .rst_ni  (w_rst_n),
      .wr_i    (w_wr & (wb_adr_i == bank_base(b))),
      .clr_i   (w_update),
      .dat_i   (wb_dat_i[COEF_BITS-1:0]),
      .stage_o (w_flat),
      .count_o (w_count[b])
    );

    assign w_stage[Off*COEF_BITS +: Depth*COEF_BITS] = w_flat;
    assign w_head[b] = w_flat[COEF_BITS-1:0];
  end

  // Unmapped and unaligned addresses fall through to zero.
  always_comb begin
    w_rdata = '0;
    if (wb_adr_i == CTRL_ADDR) w_rdata[CTRL_ENABLE_BIT] = r_enable;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (wb_adr_i == bank_base(b)) begin
        w_rdata[31:24]          = w_count[b];
        w_rdata[COEF_BITS-1:0]  = w_head[b];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ack    <= 1'b0;
      r_update <= 1'b0;
      r_enable <= 1'b0;
      r_bypass <= 1'b1;
      r_dat    <= '0;
      r_coef   <= '0;
    end else begin
      r_ack    <= w_req;
      r_update <= w_update;
      r_dat    <= (w_req & ~wb_we_i) ? w_rdata : 32'h0;
      if (w_update) r_coef <= w_stage;
      if (w_ctrl_wr) begin
        r_enable <= wb_dat_i[CTRL_ENABLE_BIT];
        r_bypass <= ~wb_dat_i[CTRL_ENABLE_BIT];
      end
    end
  end

  assign w_unused = ^{wb_sel_i, wb_dat_i[31:COEF_BITS]};

  assign wb_ack_o = r_ack;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = r_dat;
  assign coef_o   = r_coef;
  assign update_o = r_update;
  assign bypass_o = r_bypass;

endmodule
